// File: rtl/bp_cce_pkg.sv
// Shared CCE types: coherence states, speculation-bit record and the
// spec-resolver FSM state encoding.
package bp_cce_pkg;

  typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;

  typedef struct packed {
    logic           spec;
    logic           squash;
    logic           fwd_mod;
    bp_coh_states_e state;
  } bp_cce_spec_s;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WAIT   = 3'd2,
    SEND   = 3'd3,
    CLEAR  = 3'd4
  } bp_cce_spec_resolve_state_e;

endpackage

// File: rtl/bp_cce_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module bp_cce_sat_counter #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               incr_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp = {width_p{1'b1}};
  localparam logic [width_p-1:0] one_lp = {{(width_p-1){1'b0}}, 1'b1};

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (incr_i && (count_q != max_lp)) begin
      count_d = count_q + one_lp;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_cce_spec_resolver.sv
// Holds one memory response, polls its speculation bits until resolved, then
// drops or forwards it and clears the squash/fwd_mod bits for its way group.
module bp_cce_spec_resolver
  import bp_cce_pkg::*;
#(
  parameter int addr_width_p    = 40,
  parameter int payload_width_p = 64,
  parameter int cnt_width_p     = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       mem_resp_v_i,
  output logic                       mem_resp_ready_o,
  input  logic [addr_width_p-1:0]    mem_resp_addr_i,
  input  logic                       mem_resp_bypass_i,
  input  logic [payload_width_p-1:0] mem_resp_data_i,

  output logic                       spec_r_v_o,
  output logic [addr_width_p-1:0]    spec_r_addr_o,
  output logic                       spec_r_bypass_o,
  input  bp_cce_spec_s               spec_i,

  output logic                       spec_w_v_o,
  output logic [addr_width_p-1:0]    spec_w_addr_o,
  output logic                       spec_w_bypass_o,
  output logic                       spec_v_o,
  output logic                       squash_v_o,
  output logic                       fwd_mod_v_o,
  output logic                       state_v_o,
  output bp_cce_spec_s               spec_o,

  output logic                       resp_v_o,
  input  logic                       resp_ready_i,
  output logic [addr_width_p-1:0]    resp_addr_o,
  output logic [payload_width_p-1:0] resp_data_o,
  output logic                       resp_fwd_mod_o,
  output bp_coh_states_e             resp_state_o,

  output logic                       busy_o,
  output logic [cnt_width_p-1:0]     squash_cnt_o,
  output logic [cnt_width_p-1:0]     wait_cnt_o
);

  bp_cce_spec_resolve_state_e  state_q;
  logic [addr_width_p-1:0]     buf_addr_q;
  logic                        buf_bypass_q;
  logic [payload_width_p-1:0]  buf_data_q;
  logic                        dropped_q;
  logic                        fwd_mod_q;
  bp_coh_states_e              coh_state_q;
  logic                        ready_q;
  logic                        spec_r_v_q;
  logic                        resp_v_q;
  logic                        spec_w_v_q;

  // Handshake flags are registered per next state so they are all low in reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      buf_addr_q   <= '0;
      buf_bypass_q <= 1'b0;
      buf_data_q   <= '0;
      dropped_q    <= 1'b0;
      fwd_mod_q    <= 1'b0;
      coh_state_q  <= e_COH_I;
      ready_q      <= 1'b0;
      spec_r_v_q   <= 1'b0;
      resp_v_q     <= 1'b0;
      spec_w_v_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_resp_v_i && ready_q) begin
            buf_addr_q   <= mem_resp_addr_i;
            buf_bypass_q <= mem_resp_bypass_i;
            buf_data_q   <= mem_resp_data_i;
            dropped_q    <= 1'b0;
            fwd_mod_q    <= 1'b0;
            coh_state_q  <= e_COH_I;
            ready_q      <= 1'b0;
            spec_r_v_q   <= 1'b1;
            state_q      <= LOOKUP;
          end else begin
            ready_q      <= 1'b1;
          end
        end
        LOOKUP, WAIT: begin
          if (spec_i.spec) begin
            state_q     <= WAIT;
          end else if (spec_i.squash) begin
            dropped_q   <= 1'b1;
            spec_r_v_q  <= 1'b0;
            spec_w_v_q  <= 1'b1;
            state_q     <= CLEAR;
          end else begin
            fwd_mod_q   <= spec_i.fwd_mod;
            coh_state_q <= spec_i.state;
            spec_r_v_q  <= 1'b0;
            resp_v_q    <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (resp_ready_i) begin
            resp_v_q   <= 1'b0;
            spec_w_v_q <= 1'b1;
            state_q    <= CLEAR;
          end else begin
            resp_v_q   <= 1'b1;
          end
        end
        CLEAR: begin
          spec_w_v_q <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          ready_q    <= 1'b0;
          spec_r_v_q <= 1'b0;
          resp_v_q   <= 1'b0;
          spec_w_v_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign mem_resp_ready_o = ready_q;

  assign spec_r_v_o      = spec_r_v_q;
  assign spec_r_addr_o   = buf_addr_q;
  assign spec_r_bypass_o = buf_bypass_q;

  // Only squash and fwd_mod are cleared; the spec bit belongs to the issue path.
  assign spec_w_v_o      = spec_w_v_q;
  assign spec_w_addr_o   = buf_addr_q;
  assign spec_w_bypass_o = buf_bypass_q;
  assign spec_v_o        = 1'b0;
  assign squash_v_o      = spec_w_v_q;
  assign fwd_mod_v_o     = spec_w_v_q;
  assign state_v_o       = 1'b0;
  assign spec_o          = '0;

  assign resp_v_o        = resp_v_q;
  assign resp_addr_o     = buf_addr_q;
  assign resp_data_o     = buf_data_q;
  assign resp_fwd_mod_o  = fwd_mod_q;
  assign resp_state_o    = coh_state_q;

  assign busy_o          = (state_q != IDLE);

  bp_cce_sat_counter #(.width_p(cnt_width_p)) squash_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .incr_i    ((state_q == CLEAR) && dropped_q),
    .count_o   (squash_cnt_o)
  );

  bp_cce_sat_counter #(.width_p(cnt_width_p)) wait_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .incr_i    (state_q == WAIT),
    .count_o   (wait_cnt_o)
  );

endmodule
